// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard/stall controller.
// The datapath side is the master; the controller is the slave.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_reg_write;
    logic             ex_branch;
    logic             ex_zero;
    logic [4:0]       mem_rd;
    logic             mem_reg_write;
    logic             dmem_req;
    logic             dmem_ready;
    logic [4:0]       wb_rd;
    logic             wb_reg_write;

    logic [1:0]       forward_a;
    logic [1:0]       forward_b;
    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_write;
    logic             ex_mem_write;
    logic             pc_sel;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             mem_wb_flush;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd,
        output ex_mem_read, ex_reg_write, ex_branch, ex_zero,
        output mem_rd, mem_reg_write, dmem_req, dmem_ready,
        output wb_rd, wb_reg_write,
        input  forward_a, forward_b,
        input  pc_write, if_id_write, id_ex_write, ex_mem_write,
        input  pc_sel, if_id_flush, id_ex_flush, mem_wb_flush,
        input  mem_timeout, stall_count, flush_count
    );

    modport slave (
        input  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd,
        input  ex_mem_read, ex_reg_write, ex_branch, ex_zero,
        input  mem_rd, mem_reg_write, dmem_req, dmem_ready,
        input  wb_rd, wb_reg_write,
        output forward_a, forward_b,
        output pc_write, if_id_write, id_ex_write, ex_mem_write,
        output pc_sel, if_id_flush, id_ex_flush, mem_wb_flush,
        output mem_timeout, stall_count, flush_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline: operand forwarding,
// stall/flush steering, a data-memory wait FSM with timeout and perf counters.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  bus
);
    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] TIMEOUT_V = WCNT_W'(MEM_TIMEOUT);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    state_t            w_cur_state;
    logic [WCNT_W-1:0] r_wait_cnt;
    logic [WCNT_W-1:0] w_next_wait_cnt;
    logic              r_mem_timeout;
    logic              w_set_timeout;
    logic [CNT_W-1:0]  r_stall_count;
    logic [CNT_W-1:0]  r_flush_count;

    logic w_release;
    logic w_mem_stall;
    logic w_take_br;
    logic w_load_use;
    logic w_pc_write;
    logic w_if_id_write;
    logic w_id_ex_write;
    logic w_ex_mem_write;
    logic w_pc_sel;
    logic w_if_id_flush;
    logic w_id_ex_flush;
    logic w_mem_wb_flush;

    // RegWrite of the instruction in EX plays no part in any hazard rule.
    logic w_unused;
    assign w_unused = bus.ex_reg_write;

    // EX/MEM result is younger than MEM/WB, so it wins when both match.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (bus.mem_reg_write && (bus.mem_rd != 5'd0) && (bus.mem_rd == rs))
            return 2'b10;
        else if (bus.wb_reg_write && (bus.wb_rd != 5'd0) && (bus.wb_rd == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign bus.forward_a = fwd_sel(bus.ex_rs1);
    assign bus.forward_b = fwd_sel(bus.ex_rs2);

    // While reset is held the steering logic behaves as if the FSM were in RUN.
    assign w_cur_state = reset ? RUN : r_state;
    assign w_release   = (w_cur_state == MEM_WAIT) && (r_wait_cnt == TIMEOUT_V);
    assign w_mem_stall = bus.dmem_req && !bus.dmem_ready && !w_release;
    assign w_take_br   = bus.ex_branch && bus.ex_zero;
    assign w_load_use  = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                         ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            r_state       <= RUN;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_wait_cnt    <= w_next_wait_cnt;
            r_mem_timeout <= r_mem_timeout | w_set_timeout;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: defaults first so no path through the block leaves a signal
        // unassigned, which would infer a latch.
        w_next_state    = r_state;
        w_next_wait_cnt = r_wait_cnt;
        w_set_timeout   = 1'b0;
        case (r_state)
            RUN: begin
                if (bus.dmem_req && !bus.dmem_ready) begin
                    w_next_state    = MEM_WAIT;
                    w_next_wait_cnt = WCNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (bus.dmem_ready) begin
                    w_next_state    = RUN;
                    w_next_wait_cnt = '0;
                end else if (r_wait_cnt < TIMEOUT_V) begin
                    w_next_wait_cnt = r_wait_cnt + 1'b1;
                end else begin
                    w_next_state    = RUN;
                    w_next_wait_cnt = '0;
                    w_set_timeout   = 1'b1;
                end
            end
            default: begin
                w_next_state    = RUN;
                w_next_wait_cnt = '0;
            end
        endcase
    end

    // Output steering: a pending branch or load-use is held off by a memory stall.
    always_comb begin
        w_pc_write     = 1'b1;
        w_if_id_write  = 1'b1;
        w_id_ex_write  = 1'b1;
        w_ex_mem_write = 1'b1;
        w_pc_sel       = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_ex_flush  = 1'b0;
        w_mem_wb_flush = 1'b0;
        if (w_mem_stall) begin
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_id_ex_write  = 1'b0;
            w_ex_mem_write = 1'b0;
            w_mem_wb_flush = 1'b1;
        end else if (w_take_br) begin
            w_pc_sel      = 1'b1;
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
        end else if (w_load_use) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_id_ex_flush = 1'b1;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (!w_pc_write && (r_stall_count != '1))
                r_stall_count <= r_stall_count + 1'b1;
            if (w_pc_sel && (r_flush_count != '1))
                r_flush_count <= r_flush_count + 1'b1;
        end
    end

    assign bus.pc_write     = w_pc_write;
    assign bus.if_id_write  = w_if_id_write;
    assign bus.id_ex_write  = w_id_ex_write;
    assign bus.ex_mem_write = w_ex_mem_write;
    assign bus.pc_sel       = w_pc_sel;
    assign bus.if_id_flush  = w_if_id_flush;
    assign bus.id_ex_flush  = w_id_ex_flush;
    assign bus.mem_wb_flush = w_mem_wb_flush;
    assign bus.mem_timeout  = r_mem_timeout;
    assign bus.stall_count  = r_stall_count;
    assign bus.flush_count  = r_flush_count;
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RISC-V core. It watches the register fields and control bits in the ID, EX, MEM and WB stages and drives four kinds of outputs:
- forwarding selects for the ALU operand muxes;
- write enables and flushes for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers;
- a multi-cycle data-memory wait FSM with a timeout;
- stall and flush performance counters.

## Interface

Parameters:
- MEM_TIMEOUT, 16: maximum number of stalled cycles for one data-memory access. Must be ≥ 1.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- id_rs1, id_rs2  input  5  source registers of the instruction in IF/ID.
- ex_rs1, ex_rs2, ex_rd  input  5  register fields held in ID/EX.
- ex_mem_read, ex_reg_write, ex_branch, ex_zero  input  1  ID/EX control bits and the ALU zero flag.
- mem_rd  input  5  EX/MEM destination register.
- mem_reg_write  input  1  EX/MEM RegWrite.
- dmem_req  input  1  EX/MEM instruction performs a load or store.
- dmem_ready  input  1  data memory completes the access this cycle.
- wb_rd  input  5  MEM/WB destination register.
- wb_reg_write  input  1  MEM/WB RegWrite.
- forward_a, forward_b  output  2  operand selects: 00 = ID/EX read data, 01 = MEM/WB write-back value, 10 = EX/MEM ALU result. 11 is never driven.
- pc_write, if_id_write, id_ex_write, ex_mem_write  output  1  register enables.
- pc_sel  output  1  1 = load the branch target into the PC.
- if_id_flush, id_ex_flush, mem_wb_flush  output  1  insert a bubble (zero all control bits) on the next edge.
- mem_timeout  output  1  sticky error flag.
- stall_count, flush_count  output  CNT_W  saturating performance counters.

## Operation

Forwarding (combinational, operand A shown; B is identical using ex_rs2):
- forward_a = 10 if mem_reg_write and mem_rd ≠ 0 and mem_rd == ex_rs1.
- Otherwise 01 if wb_reg_write and wb_rd ≠ 0 and wb_rd == ex_rs1.
- Otherwise 00.
- The EX/MEM match always wins over the MEM/WB match.

Hazard terms:
- mem_stall = dmem_req & ~dmem_ready & ~release, where release = (state == MEM_WAIT) & (wait_cnt == MEM_TIMEOUT).
- take_br = ex_branch & ex_zero.
- load_use = ex_mem_read & (ex_rd ≠ 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).

Priority: mem_stall, then take_br, then load_use.

- **mem_stall:**
  - pc_write = if_id_write = id_ex_write = ex_mem_write = 0.
  - mem_wb_flush = 1.
  - All other flushes = 0 and pc_sel = 0. A pending branch or load-use is frozen with the pipeline and acted on in the first cycle after the stall ends.
- **take_br:**
  - pc_sel = 1, if_id_flush = 1, id_ex_flush = 1.
  - All enables = 1.
  - load_use in the same cycle is ignored, because the instruction in ID is being flushed.
- **load_use:**
  - pc_write = 0, if_id_write = 0.
  - id_ex_flush = 1.
  - id_ex_write and ex_mem_write stay 1.
- **None of the above:** all enables = 1, all flushes = 0, pc_sel = 0.

Memory-wait FSM, states RUN and MEM_WAIT:
- RUN → MEM_WAIT when dmem_req & ~dmem_ready; wait_cnt ← 1.
- MEM_WAIT → RUN when dmem_ready. This is the release cycle with no stall.
- MEM_WAIT, ~dmem_ready, wait_cnt < MEM_TIMEOUT: stay in MEM_WAIT; wait_cnt ← wait_cnt + 1.
- MEM_WAIT, ~dmem_ready, wait_cnt == MEM_TIMEOUT:
  - This cycle is not a stall cycle (the access is treated as complete).
  - mem_timeout ← 1; the flag stays set until reset.
  - Next state is RUN.

Counters:
- stall_count increments in every cycle where mem_stall or load_use gates pc_write to 0.
- flush_count increments in every cycle where take_br is acted on (pc_sel = 1).
- Both counters saturate at 2^CNT_W − 1.

## Timing

- Forwarding, enables, flushes and pc_sel are combinational from inputs and state in the same cycle.
- state, wait_cnt, mem_timeout and both counters are registered.
- Reset values:
  - state = RUN, wait_cnt = 0, mem_timeout = 0, stall_count = 0, flush_count = 0.
  - During reset the combinational outputs follow the rules above with state = RUN.
- A load-use hazard costs exactly 1 stall cycle. A taken branch costs 2 flushed slots.
- Access latency and stall length:
  - An access ready in its first MEM cycle costs 0 stall cycles.
  - An access ready after k extra cycles costs k stall cycles, for 1 ≤ k ≤ MEM_TIMEOUT.
  - An access never ready costs exactly MEM_TIMEOUT stall cycles, then is released.
- dmem_req stays high through a stall because EX/MEM is frozen.
- Reset asserted in MEM_WAIT returns the FSM to RUN on the next edge and clears wait_cnt, mem_timeout and both counters.

## Test plan

- **EX/MEM and MEM/WB both match:** mem_rd = wb_rd = 5, both RegWrite = 1, ex_rs1 = 5, ex_rs2 = 0 → forward_a = 10, forward_b = 00. With mem_reg_write = 0 → forward_a = 01.
- **Load-use:** ex_mem_read = 1, ex_rd = 7, id_rs2 = 7 → one cycle with pc_write = 0, if_id_write = 0, id_ex_flush = 1; stall_count goes 0 → 1.
- **Taken branch with simultaneous load-use:** ex_branch = ex_zero = 1 plus a load-use match → pc_sel = 1, if_id_flush = id_ex_flush = 1, pc_write = 1; flush_count = 1, stall_count unchanged.
- **Memory wait:** dmem_req = 1, dmem_ready low for 3 cycles then high → exactly 3 cycles with all enables 0 and mem_wb_flush = 1; FSM back in RUN; stall_count = 3.
- **Timeout:** MEM_TIMEOUT = 4, dmem_ready held 0 → 4 stall cycles, then a release cycle; mem_timeout = 1 and stays 1 until reset.
- **Reset mid-wait, then branch pending during a stall:** reset asserted in MEM_WAIT → state RUN and counters 0 after the edge. A taken branch arriving while dmem_ready = 0 → pc_sel = 0 until the stall ends, then pc_sel = 1 for one cycle.
